// File: rtl/alu_exec_unit_if.sv
// Handshake and operand/result bundle between the ID/EX latch, the EX ALU and the EX/MEM stage.
interface alu_exec_unit_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op_i;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            funct7_0;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic [3:0]      alu_code;

    modport master (
        output in_valid, alu_op_i, funct3, funct7_5, funct7_0, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, alu_code
    );

    modport slave (
        input  in_valid, alu_op_i, funct3, funct7_5, funct7_0, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal, alu_code
    );
endinterface

// File: rtl/alu_exec_unit.sv
// EX-stage RV32I ALU: ALUOp/funct decode, registered result with valid/ready on both sides.
// Define ALU_MUL_EN to add an iterative shift-add MUL (XLEN cycles through the BUSY state).
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd1
`ifdef ALU_MUL_EN
        ,
        S_BUSY = 2'd2
`endif
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            zero_reg, zero_next;
    logic            illegal_reg, illegal_next;
    logic [3:0]      code_reg, code_next;

    logic [3:0]      dec_code;
    logic            dec_illegal;
    logic [XLEN-1:0] exec_result;
    logic [SHW-1:0]  shamt;
    logic            in_ready_w;
    logic            accept;

`ifdef ALU_MUL_EN
    logic            dec_mul;
    logic [XLEN-1:0] acc_reg, acc_next;
    logic [XLEN-1:0] mcand_reg, mcand_next;
    logic [XLEN-1:0] mplier_reg, mplier_next;
    logic [SHW-1:0]  cnt_reg, cnt_next;
    logic [XLEN-1:0] acc_step;

    assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`endif

    assign shamt      = bus.op_b[SHW-1:0];
    assign in_ready_w = (state_reg == S_IDLE) || ((state_reg == S_DONE) && bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.illegal   = illegal_reg;
    assign bus.alu_code  = code_reg;

    always_comb begin
        dec_code    = OP_ADD;
        dec_illegal = 1'b0;
`ifdef ALU_MUL_EN
        dec_mul     = 1'b0;
`endif
        case (bus.alu_op_i)
            2'b00: dec_code = OP_ADD;
            2'b01: dec_code = OP_SUB;
            2'b10: begin
                if (bus.funct7_0) begin
`ifdef ALU_MUL_EN
                    if (bus.funct3 == 3'b000) begin
                        dec_code = OP_MUL;
                        dec_mul  = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
`else
                    dec_illegal = 1'b1;
`endif
                end else begin
                    case ({bus.funct7_5, bus.funct3})
                        4'b0000: dec_code = OP_ADD;
                        4'b1000: dec_code = OP_SUB;
                        4'b0001: dec_code = OP_SLL;
                        4'b0010: dec_code = OP_SLT;
                        4'b0011: dec_code = OP_SLTU;
                        4'b0100: dec_code = OP_XOR;
                        4'b0101: dec_code = OP_SRL;
                        4'b1101: dec_code = OP_SRA;
                        4'b0110: dec_code = OP_OR;
                        4'b0111: dec_code = OP_AND;
                        default: dec_illegal = 1'b1;
                    endcase
                end
            end
            default: begin
                // I-type: funct7_5 only selects SRAI; every funct3 is legal.
                case (bus.funct3)
                    3'b000:  dec_code = OP_ADD;
                    3'b001:  dec_code = OP_SLL;
                    3'b010:  dec_code = OP_SLT;
                    3'b011:  dec_code = OP_SLTU;
                    3'b100:  dec_code = OP_XOR;
                    3'b101:  dec_code = bus.funct7_5 ? OP_SRA : OP_SRL;
                    3'b110:  dec_code = OP_OR;
                    default: dec_code = OP_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        exec_result = '0;
        case (dec_code)
            OP_ADD:  exec_result = bus.op_a + bus.op_b;
            OP_SUB:  exec_result = bus.op_a - bus.op_b;
            OP_SLL:  exec_result = bus.op_a << shamt;
            OP_SRL:  exec_result = bus.op_a >> shamt;
            OP_SRA:  exec_result = $unsigned($signed(bus.op_a) >>> shamt);
            OP_SLT:  exec_result = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            OP_SLTU: exec_result = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
            OP_AND:  exec_result = bus.op_a & bus.op_b;
            OP_OR:   exec_result = bus.op_a | bus.op_b;
            OP_XOR:  exec_result = bus.op_a ^ bus.op_b;
            default: exec_result = '0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        result_next  = result_reg;
        zero_next    = zero_reg;
        illegal_next = illegal_reg;
        code_next    = code_reg;
`ifdef ALU_MUL_EN
        acc_next     = acc_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        cnt_next     = cnt_reg;
`endif
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (dec_mul) begin
                        state_next  = S_BUSY;
                        acc_next    = '0;
                        mcand_next  = bus.op_a;
                        mplier_next = bus.op_b;
                        cnt_next    = '0;
                    end else
`endif
                    begin
                        state_next   = S_DONE;
                        result_next  = dec_illegal ? '0 : exec_result;
                        zero_next    = dec_illegal || (exec_result == '0);
                        illegal_next = dec_illegal;
                        code_next    = dec_illegal ? OP_ADD : dec_code;
                    end
                end else if ((state_reg == S_DONE) && bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
`ifdef ALU_MUL_EN
            S_BUSY: begin
                // One multiplier bit per cycle; the last step writes the result directly.
                acc_next    = acc_step;
                mcand_next  = mcand_reg << 1;
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + SHW'(1);
                if (cnt_reg == SHW'(XLEN-1)) begin
                    state_next   = S_DONE;
                    result_next  = acc_step;
                    zero_next    = (acc_step == '0);
                    illegal_next = 1'b0;
                    code_next    = OP_MUL;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
            code_reg    <= OP_ADD;
`ifdef ALU_MUL_EN
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            cnt_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            result_reg  <= result_next;
            zero_reg    <= zero_next;
            illegal_reg <= illegal_next;
            code_reg    <= code_next;
`ifdef ALU_MUL_EN
            acc_reg     <= acc_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            cnt_reg     <= cnt_next;
`endif
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit against a spec-level model and result queue.
module tb_alu_exec_unit;
    localparam int XLEN = 32;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        ill;
        logic [3:0]  code;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    exp_t q[$];

    alu_exec_unit_if #(.XLEN(XLEN)) bus ();

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Spec-level model: operation name from the decode table, value from plain arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                                   input logic f70, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   kind;      // 0..10 = alu code, -1 = illegal
        logic [63:0] prod;
        logic [31:0] v;
        kind = -1;
        case (op)
            2'd0: kind = 0;
            2'd1: kind = 1;
            2'd2: begin
                if (f70) kind = (MUL_EN && f3 == 3'd0) ? 10 : -1;
                else case ({f75, f3})
                    4'b0000: kind = 0;  4'b1000: kind = 1;  4'b0001: kind = 2;
                    4'b0010: kind = 8;  4'b0011: kind = 9;  4'b0100: kind = 5;
                    4'b0101: kind = 6;  4'b1101: kind = 7;  4'b0110: kind = 4;
                    4'b0111: kind = 3;  default: kind = -1;
                endcase
            end
            default: begin
                case (f3)
                    3'd0: kind = 0;  3'd1: kind = 2;  3'd2: kind = 8;  3'd3: kind = 9;
                    3'd4: kind = 5;  3'd5: kind = f75 ? 7 : 6;  3'd6: kind = 4;
                    default: kind = 3;
                endcase
            end
        endcase
        prod = {32'd0, a} * {32'd0, b};
        case (kind)
            0:  v = a + b;
            1:  v = a - b;
            2:  v = a << b[4:0];
            3:  v = a & b;
            4:  v = a | b;
            5:  v = a ^ b;
            6:  v = a >> b[4:0];
            7:  v = $unsigned($signed(a) >>> b[4:0]);
            8:  v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9:  v = (a < b) ? 32'd1 : 32'd0;
            10: v = prod[31:0];
            default: v = 32'd0;
        endcase
        e.r    = v;
        e.z    = (kind < 0) || (v == 32'd0);
        e.ill  = (kind < 0);
        e.code = (kind < 0) ? 4'd0 : 4'(kind);
        e.acc  = 0;
        e.lat  = (kind == 10) ? XLEN : 0;
        return e;
    endfunction

    // Every cycle: out_valid/in_ready against the queued expectations, result when valid.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            bit exp_valid;
            bit exp_rdy;
            exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= q[0].lat);
            exp_rdy   = (q.size() == 0) || (exp_valid && bus.out_ready);
            check("out_valid", bus.out_valid, exp_valid);
            check("in_ready", bus.in_ready, exp_rdy);
            if (exp_valid && bus.out_valid) begin
                check("result", bus.result, q[0].r);
                check("zero", bus.zero, q[0].z);
                check("illegal", bus.illegal, q[0].ill);
                check("alu_code", bus.alu_code, q[0].code);
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                        input logic f70, input logic [31:0] a, input logic [31:0] b, input bit rnd);
        exp_t e;
        bit   rdy;
        int   guard;
        bus.alu_op_i = op;  bus.funct3 = f3;  bus.funct7_5 = f75;  bus.funct7_0 = f70;
        bus.op_a = a;       bus.op_b = b;     bus.in_valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
            guard++;
            if (guard > 200) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        if (rdy) begin
            e = model(op, f3, f75, f70, a, b);
            e.acc = cyc;
            q.push_back(e);
            n_vec++;
            $display("txn %0d: op=%0d f3=%0d f7_5=%0d f7_0=%0d a=%h b=%h -> exp %h ill=%0d code=%0d",
                     n_vec, op, f3, f75, f70, a, b, e.r, e.ill, e.code);
        end
        bus.in_valid = 1'b0;
        if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic expect_lit(input string nm, input logic [31:0] r, input logic ill,
                              input logic [3:0] code, input logic z, input int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 100);
        check({nm, "_lat"}, n, lat);
        check({nm, "_result"}, bus.result, r);
        check({nm, "_illegal"}, bus.illegal, ill);
        check({nm, "_code"}, bus.alu_code, code);
        check({nm, "_zero"}, bus.zero, z);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t m;
        int   guard;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;  bus.alu_op_i = 2'd0;  bus.funct3 = 3'd0;
        bus.funct7_5 = 1'b0;  bus.funct7_0 = 1'b0;  bus.op_a = '0;  bus.op_b = '0;
        bus.out_ready = 1'b1;

        m = model(2'd2, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7);
        check("model_sub", m.r, 32'hFFFF_FFFE);
        m = model(2'd3, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
        check("model_srai", m.r, 32'hF800_0000);
        m = model(2'd2, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        check("model_slt", m.r, 32'd1);
        m = model(2'd2, 3'd7, 1'b1, 1'b0, 32'd3, 32'd4);
        check("model_illegal", m.ill, 1'b1);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", bus.zero, 1'b0);
        check("rst_illegal", bus.illegal, 1'b0);
        check("rst_code", bus.alu_code, 4'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1 chk_en = 1'b1;

        send(2'd2, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 1'b0);
        expect_lit("sub", 32'hFFFF_FFFE, 1'b0, 4'd1, 1'b0, 1);
        send(2'd3, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 1'b0);
        expect_lit("srai", 32'hF800_0000, 1'b0, 4'd7, 1'b0, 1);
        send(2'd3, 3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 1'b0);
        expect_lit("srli", 32'h0800_0000, 1'b0, 4'd6, 1'b0, 1);
        send(2'd2, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        expect_lit("slt", 32'd1, 1'b0, 4'd8, 1'b0, 1);
        send(2'd2, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        expect_lit("sltu", 32'd0, 1'b0, 4'd9, 1'b1, 1);
        send(2'd2, 3'd7, 1'b1, 1'b0, 32'd9, 32'd9, 1'b0);
        expect_lit("illegal", 32'd0, 1'b1, 4'd0, 1'b1, 1);
        send(2'd2, 3'd0, 1'b0, 1'b1, 32'd12345, 32'd678, 1'b0);
        if (MUL_EN) expect_lit("mul", 32'd8369910, 1'b0, 4'd10, 1'b0, XLEN + 1);
        else        expect_lit("mul_off", 32'd0, 1'b1, 4'd0, 1'b1, 1);

        // Backpressure: result held five cycles, then a new op follows with no bubble.
        bus.out_ready = 1'b0;
        send(2'd0, 3'd0, 1'b0, 1'b0, 32'd10, 32'd20, 1'b0);
        fork
            send(2'd2, 3'd4, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold", bus.result, 32'd30);
                    check("bp_in_ready", bus.in_ready, 1'b0);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        expect_lit("bp_new", 32'h0000_FF00, 1'b0, 4'd5, 1'b0, 1);

        // Reset in the middle of a multiply (or a held result when MUL is compiled out).
        bus.out_ready = 1'b0;
        send(2'd2, 3'd0, 1'b0, 1'b1, 32'd12345, 32'd678, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        #1;
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_result", bus.result, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(2'd0, 3'd0, 1'b0, 1'b0, 32'd2, 32'd3, 1'b0);
        expect_lit("post_rst_add", 32'd5, 1'b0, 4'd0, 1'b0, 1);

        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            logic [2:0] f3;
            logic f75, f70;
            op  = 2'($urandom_range(0, 3));
            f3  = 3'($urandom_range(0, 7));
            f75 = 1'($urandom_range(0, 1));
            f70 = ($urandom_range(0, 7) == 0);
            if (i % 50 == 7) begin
                op = 2'd2; f3 = 3'd0; f70 = 1'b1;
            end
            send(op, f3, f75, f70, rnd_operand(), rnd_operand(), 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end

        bus.out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        check("drain_empty", q.size(), 32'd0);
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errors);
        $finish;
    end
endmodule
